// File: rtl/ccg_bist_pkg.sv
// ccg_bist_pkg: shared definitions for the BIST harness.
// Contents:
//   - FSM state enum (IDLE, RUN, DONE)
//   - LFSR tap constant and the default nonzero seed
//   - LFSR next-state helper function
package ccg_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bist_state_t;

  // Taps for x^32 + x^22 + x^2 + x + 1. Bit i holds the LFSR stage whose
  // output feeds the XOR, so the set bits are 31, 21, 1 and 0.
  localparam logic [31:0] LFSR_TAPS     = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED_DEF = 32'h0000_0001;

  // One Fibonacci step: shift left, XOR of the tapped bits enters bit 0.
  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    return {cur[30:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ccg_misr.sv
// ccg_misr: multiple-input signature register.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - load zero on the next edge (priority over enable)
//   enable    - compact data into the signature on the next edge
//   data      - N_IN_BITS response bits, zero-extended to SIG_W
//   sig       - current signature (registered)
//   sig_next  - value sig would take if enable were asserted now
module ccg_misr
  import ccg_bist_pkg::*;
#(
  parameter int                SIG_W     = 16,
  parameter int                N_IN_BITS = 2,
  parameter logic [SIG_W-1:0]  SIG_POLY  = 16'h1021
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [N_IN_BITS-1:0] data,
  output logic [SIG_W-1:0]     sig,
  output logic [SIG_W-1:0]     sig_next
);

  logic [SIG_W-1:0] data_ext_s;

  // Next signature: shift, conditional polynomial feedback, fold in response.
  always_comb begin
    data_ext_s                  = {SIG_W{1'b0}};
    data_ext_s[N_IN_BITS-1:0]   = data;
    sig_next = {sig[SIG_W-2:0], 1'b0}
             ^ (sig[SIG_W-1] ? SIG_POLY : {SIG_W{1'b0}})
             ^ data_ext_s;
  end

  // Signature register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= {SIG_W{1'b0}};
    end else if (clear) begin
      sig <= {SIG_W{1'b0}};
    end else if (enable) begin
      sig <= sig_next;
    end else begin
      sig <= sig;
    end
  end

endmodule

// File: rtl/ccg_bist_harness.sv
// ccg_bist_harness: LFSR stimulus generator + MISR response compactor that
// drives a circuit under test for num_pat patterns and compares the final
// signature with a golden value.
// Optional feature: define CCG_BIST_ABORT_EN to add the abort input, which
// cancels a run in progress (signature retained, no pass/done).
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start           - launch pulse (accepted in IDLE/DONE only)
//   abort           - (CCG_BIST_ABORT_EN only) cancel a run
//   seed            - LFSR seed (0 is replaced by 1)
//   num_pat         - number of patterns to compact
//   golden          - expected signature
//   x_out           - registered stimulus (low N_IN LFSR bits)
//   f_in            - response from the circuit under test
//   busy/done/pass  - status flags (registered)
//   signature       - current MISR value
module ccg_bist_harness
  import ccg_bist_pkg::*;
#(
  parameter int               N_IN     = 6,
  parameter int               N_OUT    = 2,
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef CCG_BIST_ABORT_EN
  input  logic             abort,
`endif
  input  logic [31:0]      seed,
  input  logic [CNT_W-1:0] num_pat,
  input  logic [SIG_W-1:0] golden,
  output logic [N_IN-1:0]  x_out,
  input  logic [N_OUT-1:0] f_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  bist_state_t      state_r, state_next_s;
  logic [31:0]      lfsr_r;
  logic [31:0]      lfsr_nxt_s;
  logic [31:0]      seed_eff_s;
  logic [CNT_W-1:0] count_r;
  logic [SIG_W-1:0] golden_r;
  logic [SIG_W-1:0] sig_next_s;
  logic             load_s, zero_s, step_s, last_s, abort_s;
  logic             abort_in_s;

`ifdef CCG_BIST_ABORT_EN
  assign abort_in_s = abort;
`else
  assign abort_in_s = 1'b0;
`endif

  assign seed_eff_s = (seed == 32'h0) ? LFSR_SEED_DEF : seed;
  assign lfsr_nxt_s = lfsr_next(lfsr_r);

  // Next-state and control decode.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    zero_s       = 1'b0;
    step_s       = 1'b0;
    last_s       = 1'b0;
    abort_s      = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          if (num_pat != {CNT_W{1'b0}}) begin
            load_s       = 1'b1;
            state_next_s = RUN;
          end else begin
            zero_s       = 1'b1;
            state_next_s = DONE;
          end
        end else begin
          state_next_s = state_r;
        end
      end
      RUN: begin
        if (abort_in_s) begin
          abort_s      = 1'b1;
          state_next_s = IDLE;
        end else begin
          step_s = 1'b1;
          if (count_r == CNT_ONE) begin
            last_s       = 1'b1;
            state_next_s = DONE;
          end else begin
            state_next_s = RUN;
          end
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, LFSR, counter and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      lfsr_r   <= LFSR_SEED_DEF;
      count_r  <= {CNT_W{1'b0}};
      golden_r <= {SIG_W{1'b0}};
      x_out    <= {N_IN{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (load_s) begin
        lfsr_r   <= seed_eff_s;
        x_out    <= seed_eff_s[N_IN-1:0];
        count_r  <= num_pat;
        golden_r <= golden;
        busy     <= 1'b1;
        done     <= 1'b0;
        pass     <= 1'b0;
      end else if (zero_s) begin
        count_r  <= {CNT_W{1'b0}};
        golden_r <= golden;
        busy     <= 1'b0;
        done     <= 1'b1;
        pass     <= (golden == {SIG_W{1'b0}});
      end else if (abort_s) begin
        busy <= 1'b0;
        done <= 1'b0;
        pass <= 1'b0;
      end else if (step_s) begin
        lfsr_r  <= lfsr_nxt_s;
        x_out   <= lfsr_nxt_s[N_IN-1:0];
        count_r <= count_r - CNT_ONE;
        if (last_s) begin
          // The signature lands on this same edge, so compare its next value.
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (sig_next_s == golden_r);
        end
      end
    end
  end

  ccg_misr #(
    .SIG_W     (SIG_W),
    .N_IN_BITS (N_OUT),
    .SIG_POLY  (SIG_POLY)
  ) u_misr (
    .clk      (clk),
    .rst      (rst),
    .clear    (load_s | zero_s),
    .enable   (step_s),
    .data     (f_in),
    .sig      (signature),
    .sig_next (sig_next_s)
  );

endmodule

// File: tb/tb_ccg_bist_harness.sv
// Self-checking bench for ccg_bist_harness (default parameters).
// A behavioural model computes stimulus and signatures from the polynomial
// definitions; the circuit under test is a small combinational function of
// x_out selected by resp_mode.
module tb_ccg_bist_harness;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] seed;
  logic [15:0] num_pat;
  logic [15:0] golden;
  logic [5:0]  x_out;
  logic [1:0]  f_in;
  logic        busy, done, pass;
  logic [15:0] signature;

  int n_checks = 0;
  int n_errors = 0;
  int resp_mode = 0;

  always #5 clk = ~clk;

  ccg_bist_harness dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef CCG_BIST_ABORT_EN
    .abort     (abort),
`endif
    .seed      (seed),
    .num_pat   (num_pat),
    .golden    (golden),
    .x_out     (x_out),
    .f_in      (f_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature)
  );

  // Circuit under test.
  function automatic logic [1:0] cut(input int m, input logic [5:0] x);
    if (m == 0) return 2'b00;
    if (m == 1) return 2'b01;
    return {x[5] ^ x[2], x[0] ^ (x[4] & x[1])};
  endfunction

  always_comb f_in = cut(resp_mode, x_out);

  // Model LFSR: x^32+x^22+x^2+x+1, shift left, feedback into bit 0.
  function automatic logic [31:0] m_lfsr_step(input logic [31:0] l);
    logic fb;
    fb = l[31] ^ l[21] ^ l[1] ^ l[0];
    return {l[30:0], fb};
  endfunction

  // Model MISR: multiply by x modulo the polynomial, then add the response.
  function automatic logic [15:0] m_misr_step(input logic [15:0] m, input logic [1:0] r);
    int v;
    v = (int'(m) * 2) % 65536;
    if (m >= 16'd32768) v = v ^ 32'h1021;
    v = v ^ int'(r);
    return v[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One run from a negedge. ign_at/rst_at: pattern index at which to pulse
  // start (must be ignored) or reset; -1 disables.
  task automatic run(input logic [31:0] sd, input logic [15:0] np, input logic [15:0] gd,
                     input int fm, input int ign_at, input int rst_at,
                     output logic [15:0] sig_out);
    logic [31:0] ml;
    logic [15:0] ms;
    resp_mode = fm;
    seed = sd; num_pat = np; golden = gd; start = 1'b1;
    ml = (sd == 32'h0) ? 32'h1 : sd;
    ms = 16'h0;
    @(negedge clk);
    start = 1'b0;
    if (np == 16'd0) begin
      check("zero_done", {31'd0, done}, 32'd1);
      check("zero_busy", {31'd0, busy}, 32'd0);
      check("zero_pass", {31'd0, pass}, {31'd0, gd == 16'd0});
      check("zero_sig", {16'd0, signature}, 32'd0);
      sig_out = 16'h0;
      return;
    end
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_done", {31'd0, done}, 32'd0);
    check("start_x", {26'd0, x_out}, {26'd0, ml[5:0]});
    check("start_sig", {16'd0, signature}, 32'd0);
    for (int k = 0; k < int'(np); k++) begin
      if (k == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_x", {26'd0, x_out}, 32'd0);
        check("rst_sig", {16'd0, signature}, 32'd0);
        check("rst_flags", {29'd0, busy, done, pass}, 32'd0);
        @(negedge clk);
        check("rst_idle", {29'd0, busy, done, pass}, 32'd0);
        sig_out = 16'h0;
        return;
      end
      if (k == ign_at) begin
        start = 1'b1; seed = $urandom; num_pat = 16'($urandom_range(1, 5)); golden = 16'($urandom);
      end
      ms = m_misr_step(ms, cut(fm, ml[5:0]));
      ml = m_lfsr_step(ml);
      @(negedge clk);
      start = 1'b0;
      check("run_sig", {16'd0, signature}, {16'd0, ms});
      check("run_x", {26'd0, x_out}, {26'd0, ml[5:0]});
      check("run_busy", {31'd0, busy}, {31'd0, k < int'(np) - 1});
      check("run_done", {31'd0, done}, {31'd0, k == int'(np) - 1});
    end
    check("end_pass", {31'd0, pass}, {31'd0, ms == gd});
    repeat (2) @(negedge clk);
    check("hold_sig", {16'd0, signature}, {16'd0, ms});
    check("hold_x", {26'd0, x_out}, {26'd0, ml[5:0]});
    check("hold_flags", {29'd0, busy, done, pass}, {29'd0, 1'b0, 1'b1, ms == gd});
    sig_out = ms;
  endtask

  initial begin
    logic [15:0] s, ref_sig;
    rst = 1'b1; start = 1'b0; abort = 1'b0; seed = 32'h0; num_pat = 16'd0; golden = 16'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_x", {26'd0, x_out}, 32'd0);
    check("reset_sig", {16'd0, signature}, 32'd0);
    check("reset_flags", {29'd0, busy, done, pass}, 32'd0);

    // Zero response, 100 patterns.
    run(32'hACE1_2345, 16'd100, 16'h0000, 0, -1, -1, s);
    check("zero_resp_sig", {16'd0, s}, 32'd0);
    // Constant response 01: 0001 then 0003.
    run(32'h1234_5678, 16'd2, 16'h0003, 1, -1, -1, s);
    check("const_sig", {16'd0, s}, 32'h3);
    check("const_pass", {31'd0, pass}, 32'd1);
    run(32'h1234_5678, 16'd2, 16'h0004, 1, -1, -1, s);
    check("const_fail_pass", {31'd0, pass}, 32'd0);
    // Seed 0 substituted by 1.
    run(32'h0, 16'd3, 16'h0, 2, -1, -1, s);
    // num_pat 0 from DONE, then from IDLE-equivalent path.
    run(32'h5, 16'd0, 16'h0, 2, -1, -1, s);
    run(32'h5, 16'd0, 16'h7, 2, -1, -1, s);
    // Start during RUN is ignored.
    run(32'hDEAD_BEEF, 16'd12, 16'h0, 2, 4, -1, s);
    // Reset mid-run, then rerun reproduces the uninterrupted signature.
    run(32'h0BAD_F00D, 16'd100, 16'h0, 2, -1, -1, ref_sig);
    run(32'h0BAD_F00D, 16'd100, 16'h0, 2, -1, 50, s);
    run(32'h0BAD_F00D, 16'd100, ref_sig, 2, -1, -1, s);
    check("rerun_sig", {16'd0, s}, {16'd0, ref_sig});
    check("rerun_pass", {31'd0, pass}, 32'd1);
    // Randomized runs; golden is sometimes the correct signature.
    for (int r = 0; r < 16; r++) begin
      logic [31:0] sd;
      logic [15:0] np;
      sd = $urandom;
      np = 16'($urandom_range(1, 40));
      run(sd, np, 16'($urandom), 2, -1, -1, ref_sig);
      run(sd, np, ref_sig, 2, -1, -1, s);
      check("rand_pass", {31'd0, pass}, 32'd1);
    end

`ifdef CCG_BIST_ABORT_EN
    begin
      logic [31:0] ml;
      logic [15:0] ms;
      resp_mode = 2;
      seed = 32'h2468_ACE0; num_pat = 16'd40; golden = 16'h0; start = 1'b1;
      ml = seed; ms = 16'h0;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 10; k++) begin
        ms = m_misr_step(ms, cut(2, ml[5:0]));
        ml = m_lfsr_step(ml);
        @(negedge clk);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_flags", {29'd0, busy, done, pass}, 32'd0);
      check("abort_sig", {16'd0, signature}, {16'd0, ms});
      @(negedge clk);
      check("abort_idle", {29'd0, busy, done, pass}, 32'd0);
      check("abort_hold_sig", {16'd0, signature}, {16'd0, ms});
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ccg_bist_harness.md
CCG_BIST_HARNESS -- requirements
Module: ccg_bist_harness

Interface
REQ-001 SHALL have parameter N_IN, default 6: width of the stimulus bus driven to the circuit under test (1..32).
REQ-002 SHALL have parameter N_OUT, default 2: width of the response bus from the circuit under test (1..SIG_W).
REQ-003 SHALL have parameter SIG_W, default 16: MISR signature width (2..32).
REQ-004 SHALL have parameter SIG_POLY, default 16'h1021: MISR feedback polynomial, SIG_W bits.
REQ-005 SHALL have parameter CNT_W, default 16: pattern counter width.
REQ-006 SHALL use one clock and a synchronous, active-high reset; ports clk and rst.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 start  in  1  one-cycle pulse that launches a run.
REQ-010 seed  in  32  LFSR seed, sampled on an accepted start.
REQ-011 num_pat  in  CNT_W  pattern count, sampled on an accepted start.
REQ-012 golden  in  SIG_W  expected signature, sampled on an accepted start.
REQ-013 x_out  out  N_IN  registered stimulus to the circuit under test.
REQ-014 f_in  in  N_OUT  combinational response from the circuit under test.
REQ-015 busy, done, pass  out  1 each  status flags.
REQ-016 signature  out  SIG_W  current MISR value.

Function
REQ-017 FSM SHALL have states IDLE, RUN and DONE.
- start is accepted in IDLE or DONE.
- start is ignored in RUN.
REQ-018 Accepted start with num_pat!=0 SHALL perform these actions on that edge and go to RUN with busy=1:
- LFSR <= seed, with seed 0 replaced by 32'h1.
- MISR <= 0.
- count <= num_pat.
- x_out <= low N_IN bits of the loaded LFSR value.
REQ-019 Accepted start with num_pat==0 SHALL go straight to DONE with signature=0 and pass=(golden==0).
REQ-020 LFSR SHALL be 32-bit Fibonacci, polynomial x^32+x^22+x^2+x+1, shifting left with feedback into bit 0; x_out SHALL be its low N_IN bits.
REQ-021 Each RUN cycle SHALL do the following on the clock edge:
- MISR <= {MISR[SIG_W-2:0],0} ^ (MISR[SIG_W-1] ? SIG_POLY : 0) ^ zero-extended f_in, sampling the response to the x_out held during that cycle.
- LFSR advances once and x_out updates.
- count decrements.
REQ-022 On the edge where count==1, the FSM SHALL go to DONE, with busy=0 and done=1 from the next cycle; exactly num_pat patterns are compacted.
REQ-023 In DONE, pass SHALL be (signature==golden), evaluated against the golden value sampled at start; signature, done and pass SHALL hold until the next accepted start or reset.
REQ-024 A start accepted in DONE SHALL clear done and pass in the same edge that enters RUN.
REQ-025 x_out SHALL hold its value in IDLE and DONE.

Reset
REQ-026 rst SHALL force IDLE on the next edge, including mid-run, with no partial result retained:
- x_out=0, signature=0, busy=0, done=0, pass=0.
- LFSR=32'h1, count=0.
REQ-027 rst SHALL take priority over start in the same cycle.

Configuration
REQ-028 With macro CCG_BIST_ABORT_EN defined, port abort (in, 1) SHALL exist; abort=1 in RUN SHALL go to IDLE next edge with busy=0, done=0, pass=0 and signature retained; abort outside RUN SHALL be ignored.
REQ-029 Without CCG_BIST_ABORT_EN, no abort port SHALL exist and a RUN SHALL always complete.

Structure
REQ-030 Package ccg_bist_pkg SHALL hold the FSM state enum, the LFSR polynomial/tap constant LFSR_TAPS and the nonzero-seed constant LFSR_SEED_DEF=32'h1.
REQ-031 The MISR SHALL be a sub-module ccg_misr, parameterised by SIG_W, N_IN_BITS and SIG_POLY, with clear and enable controls.

Verification
REQ-032 f_in tied to 0, num_pat=100, golden=0 -> done after 100 RUN cycles, signature=16'h0000, pass=1.
REQ-033 f_in=2'b01 constant, num_pat=2, golden=16'h0003 -> signature 16'h0001 then 16'h0003, pass=1; rerun with golden=16'h0004 -> pass=0.
REQ-034 seed=0, num_pat=3 -> first x_out=6'h01, following x_out match the reference model LFSR sequence.
REQ-035 num_pat=0, golden=0 -> DONE on the next cycle with busy never asserted and pass=1; start pulsed during RUN -> ignored, count unaffected.
REQ-036 rst asserted mid-run at pattern 50 of 100 -> next cycle all outputs 0 and state IDLE; a fresh start reproduces the golden signature of an uninterrupted run.
REQ-037 With CCG_BIST_ABORT_EN, abort at pattern 10 -> IDLE, done=0, signature equals the model value after 10 patterns.
